chacha_bus_sequencer: RTL and testbench

- Hardware bus initiator for the chacha20_poly1305_bus register interface.
- Replaces software or bench-driven register sequencing with an autonomous sequencer:
  - accepts one key/nonce/data job on a valid/ready port;
  - issues the fixed write sequence (key, nonce, data, init, next);
  - polls status until ready, then reads back the result.
- Returns the result, plus an error flag on poll timeout, on a valid/ready response port.

---
 rtl/chacha_bus_pkg.sv | 27 ++
 rtl/chacha_bus_access.sv | 53 +++++
 rtl/chacha_bus_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_chacha_bus_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_bus_pkg.sv
// rtl/chacha_bus_pkg.sv - register map, control values and sequencer states
package chacha_bus_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_KEY    = 8'h10;
  localparam logic [7:0] ADDR_NONCE  = 8'h20;
  localparam logic [7:0] ADDR_DATA   = 8'h30;
  localparam logic [7:0] ADDR_RESULT = 8'h40;

  localparam int CTRL_INIT        = 1;
  localparam int CTRL_NEXT        = 2;
  localparam int STATUS_READY_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_NONCE,
    ST_WR_DATA,
    ST_WR_INIT,
    ST_WR_NEXT,
    ST_POLL,
    ST_RES,
    ST_RSP
  } seq_state_t;

endpackage

// File: rtl/chacha_bus_access.sv
// rtl/chacha_bus_access.sv - two-cycle bus access engine (issue cycle, then gap cycle)
module chacha_bus_access
  import chacha_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  logic gap;

  // A new access may be issued during the gap cycle, giving back-to-back accesses
  assign ready = !cs;
  assign done  = gap;
  assign rdata = read_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs         <= 1'b0;
      we         <= 1'b0;
      address    <= '0;
      write_data <= '0;
      gap        <= 1'b0;
    end else if (start && !cs) begin
      cs         <= 1'b1;
      we         <= start_we;
      address    <= start_addr;
      write_data <= start_wdata;
      gap        <= 1'b0;
    end else if (cs) begin
      cs  <= 1'b0;
      we  <= 1'b0;
      gap <= 1'b1;
    end else begin
      gap <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_bus_sequencer.sv
// rtl/chacha_bus_sequencer.sv - autonomous key/nonce/data job sequencer for the chacha register bus
module chacha_bus_sequencer
  import chacha_bus_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 512,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_nonce,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              busy,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);

  seq_state_t        state, state_n, acc_state;
  logic              pend, pend_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] key_q, nonce_q, data_q;
  logic [DATA_W-1:0] rsp_data_n;
  logic              rsp_error_n;
  logic              capture;

  logic              acc_start, acc_we, acc_ready, acc_done;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, acc_rdata;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RSP);

  // pend marks an access in flight; on its completion the next access is issued in the same cycle
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    cnt_n       = cnt;
    acc_state   = state;
    acc_start   = 1'b0;
    capture     = 1'b0;
    rsp_data_n  = rsp_data;
    rsp_error_n = rsp_error;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_n = ST_WR_KEY;
          capture = 1'b1;
          cnt_n   = '0;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        if (!pend) begin
          acc_start = acc_ready;
        end else if (acc_done) begin
          pend_n = 1'b0;
          case (state)
            ST_WR_KEY:   state_n = ST_WR_NONCE;
            ST_WR_NONCE: state_n = ST_WR_DATA;
            ST_WR_DATA:  state_n = ST_WR_INIT;
            ST_WR_INIT:  state_n = ST_WR_NEXT;
            ST_WR_NEXT:  state_n = ST_POLL;
            ST_POLL: begin
              if (acc_rdata[STATUS_READY_BIT]) begin
                state_n = ST_RES;
              end else if (cnt == CNT_W'(POLL_MAX)) begin
                state_n     = ST_RSP;
                rsp_data_n  = '0;
                rsp_error_n = 1'b1;
              end else begin
                state_n = ST_POLL;
              end
            end
            ST_RES: begin
              state_n     = ST_RSP;
              rsp_data_n  = acc_rdata;
              rsp_error_n = 1'b0;
            end
            default: state_n = ST_IDLE;
          endcase
          if (state_n != ST_RSP && state_n != ST_IDLE) begin
            acc_start = 1'b1;
            acc_state = state_n;
          end
        end
      end
    endcase
    if (acc_start) begin
      pend_n = 1'b1;
      if (acc_state == ST_POLL) begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    acc_we    = 1'b1;
    acc_addr  = '0;
    acc_wdata = '0;
    case (acc_state)
      ST_WR_KEY: begin
        acc_addr  = ADDR_W'(ADDR_KEY);
        acc_wdata = key_q;
      end
      ST_WR_NONCE: begin
        acc_addr  = ADDR_W'(ADDR_NONCE);
        acc_wdata = nonce_q;
      end
      ST_WR_DATA: begin
        acc_addr  = ADDR_W'(ADDR_DATA);
        acc_wdata = data_q;
      end
      ST_WR_INIT: begin
        acc_addr  = ADDR_W'(ADDR_CTRL);
        acc_wdata = DATA_W'(CTRL_INIT);
      end
      ST_WR_NEXT: begin
        acc_addr  = ADDR_W'(ADDR_CTRL);
        acc_wdata = DATA_W'(CTRL_NEXT);
      end
      ST_POLL: begin
        acc_we   = 1'b0;
        acc_addr = ADDR_W'(ADDR_STATUS);
      end
      ST_RES: begin
        acc_we   = 1'b0;
        acc_addr = ADDR_W'(ADDR_RESULT);
      end
      default: acc_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pend      <= 1'b0;
      cnt       <= '0;
      key_q     <= '0;
      nonce_q   <= '0;
      data_q    <= '0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      cnt       <= cnt_n;
      rsp_data  <= rsp_data_n;
      rsp_error <= rsp_error_n;
      if (capture) begin
        key_q   <= req_key;
        nonce_q <= req_nonce;
        data_q  <= req_data;
      end
    end
  end

  chacha_bus_access #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_access (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (acc_start),
    .start_we    (acc_we),
    .start_addr  (acc_addr),
    .start_wdata (acc_wdata),
    .ready       (acc_ready),
    .done        (acc_done),
    .rdata       (acc_rdata),
    .cs          (cs),
    .we          (we),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data)
  );

endmodule

// File: tb/tb_chacha_bus_sequencer.sv
// tb/tb_chacha_bus_sequencer.sv - directed bench with register responder model for chacha_bus_sequencer
module tb_chacha_bus_sequencer;

  localparam logic [511:0] K1 = {16{32'h00112233}};
  localparam logic [511:0] N1 = {16{32'h01020304}};
  localparam logic [511:0] D1 = {16{32'hdeadbeef}};
  localparam logic [511:0] R1 = {16{32'hcafef00d}};
  localparam logic [511:0] K2 = {16{32'h0badc0de}};
  localparam logic [511:0] R2 = {16{32'h12345678}};

  logic         clk, reset_n;
  logic         req_valid, req_ready;
  logic [511:0] req_key, req_nonce, req_data;
  logic         rsp_valid, rsp_ready, rsp_error, busy;
  logic [511:0] rsp_data;
  logic         cs, we;
  logic [7:0]   address;
  logic [511:0] write_data, read_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]   tr_addr[$];
  logic         tr_we[$];
  logic [511:0] tr_wd[$];
  int           tr_cyc[$];

  int           edge_n = 0, acc_edge = 0, acc_count = 0;
  int           status_total = 0, stat_base = 0, not_ready = 0;
  int           cs_double = 0;
  logic         prev_cs = 1'b0;
  logic [511:0] result_word = '0;
  int           got, rsp_cyc, tbase, acc0;

  chacha_bus_sequencer #(.ADDR_W(8), .DATA_W(512), .POLL_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_nonce(req_nonce), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .cs(cs), .we(we), .address(address),
    .write_data(write_data), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (reset_n && req_valid && req_ready) begin
      acc_edge  = edge_n;
      acc_count = acc_count + 1;
    end
    if (cs && !we) begin
      if (address == 8'h09) begin
        status_total = status_total + 1;
        read_data <= ((status_total - stat_base) > not_ready) ? 512'h1 : 512'h0;
      end else if (address == 8'h40) begin
        read_data <= result_word;
      end else begin
        read_data <= '0;
      end
    end
  end

  always @(negedge clk) begin
    if (cs) begin
      tr_addr.push_back(address);
      tr_we.push_back(we);
      tr_wd.push_back(write_data);
      tr_cyc.push_back(edge_n - acc_edge);
    end
    if (cs && prev_cs) cs_double = cs_double + 1;
    prev_cs = cs;
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_addr(input int base, input logic [7:0] a);
    int n = 0;
    for (int i = base; i < tr_addr.size(); i++) if (tr_addr[i] == a) n++;
    return n;
  endfunction

  task automatic run_job(input logic [511:0] k, input logic [511:0] n, input logic [511:0] d,
                         input int nr, input logic [511:0] res, input bit churn);
    not_ready   = nr;
    result_word = res;
    stat_base   = status_total;
    tbase       = tr_addr.size();
    acc0        = acc_count;
    @(negedge clk);
    req_key = k; req_nonce = n; req_data = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    rsp_cyc = -1;
    for (int i = 0; i < 300 && got == 0; i++) begin
      if (rsp_valid) begin
        got = 1;
        rsp_cyc = edge_n - acc_edge;
      end else begin
        if (churn) begin
          req_valid = ~req_valid;
          req_key   = ~req_key;
        end
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    check("rsp_arrived", 512'(got), 512'd1);
  endtask

  task automatic check_nominal_trace(input logic [511:0] k, input logic [511:0] n, input logic [511:0] d);
    logic [7:0]   ea[7];
    logic [511:0] ew[5];
    ea = '{8'h10, 8'h20, 8'h30, 8'h08, 8'h08, 8'h09, 8'h40};
    ew = '{k, n, d, 512'h1, 512'h2};
    check("trace_len", 512'(tr_addr.size() - tbase), 512'd7);
    if (tr_addr.size() - tbase >= 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("trace_addr%0d", i), 512'(tr_addr[tbase+i]), 512'(ea[i]));
        check($sformatf("trace_we%0d", i), 512'(tr_we[tbase+i]), (i < 5) ? 512'd1 : 512'd0);
        check($sformatf("trace_cyc%0d", i), 512'(tr_cyc[tbase+i]), 512'(2*i+1));
        if (i < 5) check($sformatf("trace_wd%0d", i), tr_wd[tbase+i], ew[i]);
      end
    end
  endtask

  initial begin
    int bp_bad;
    int hit;
    logic [511:0] held;
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_key = '0; req_nonce = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_cs", 512'(cs), 512'd0);
    check("rst_we", 512'(we), 512'd0);
    check("rst_address", 512'(address), 512'd0);
    check("rst_write_data", write_data, 512'd0);
    check("rst_rsp_valid", 512'(rsp_valid), 512'd0);
    check("rst_rsp_error", 512'(rsp_error), 512'd0);
    check("rst_rsp_data", rsp_data, 512'd0);
    check("rst_busy", 512'(busy), 512'd0);
    check("rst_req_ready", 512'(req_ready), 512'd1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rsp_ready_no_effect", 512'({rsp_valid, busy, cs}), 512'd0);

    // nominal job, status ready on first poll
    run_job(K1, N1, D1, 0, R1, 1'b0);
    check("nom_rsp_cycle", 512'(rsp_cyc), 512'd15);
    check("nom_rsp_data", rsp_data, R1);
    check("nom_rsp_error", 512'(rsp_error), 512'd0);
    check_nominal_trace(K1, N1, D1);
    @(negedge clk);
    check("nom_after_req_ready", 512'(req_ready), 512'd1);
    check("nom_after_rsp_valid", 512'(rsp_valid), 512'd0);

    // 3 not-ready polls, ready on the POLL_MAX-th read, with req churn in flight
    run_job(K2, N1, D1, 3, R2, 1'b1);
    check("poll4_rsp_cycle", 512'(rsp_cyc), 512'd21);
    check("poll4_status_reads", 512'(count_addr(tbase, 8'h09)), 512'd4);
    check("poll4_result_reads", 512'(count_addr(tbase, 8'h40)), 512'd1);
    check("poll4_rsp_data", rsp_data, R2);
    check("poll4_rsp_error", 512'(rsp_error), 512'd0);
    check("churn_key_captured", tr_wd[tbase], K2);
    check("churn_single_accept", 512'(acc_count - acc0), 512'd1);
    @(negedge clk);

    // status never ready: timeout after POLL_MAX reads
    run_job(K1, N1, D1, 1000, R1, 1'b0);
    check("to_status_reads", 512'(count_addr(tbase, 8'h09)), 512'd4);
    check("to_result_reads", 512'(count_addr(tbase, 8'h40)), 512'd0);
    check("to_rsp_error", 512'(rsp_error), 512'd1);
    check("to_rsp_data", rsp_data, 512'd0);
    check("to_rsp_cycle", 512'(rsp_cyc), 512'd19);
    @(negedge clk);

    // back-pressure on the response port
    rsp_ready = 1'b0;
    run_job(K1, N1, D1, 0, R2, 1'b0);
    held = rsp_data;
    check("bp_rsp_data", held, R2);
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== R2 || rsp_error !== 1'b0 || cs !== 1'b0 || req_ready !== 1'b0)
        bp_bad++;
    end
    check("bp_stable", 512'(bp_bad), 512'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req_ready", 512'(req_ready), 512'd1);
    check("bp_release_rsp_valid", 512'(rsp_valid), 512'd0);
    run_job(K2, N1, D1, 0, R1, 1'b0);
    check("bp_second_rsp_cycle", 512'(rsp_cyc), 512'd15);
    check("bp_second_rsp_data", rsp_data, R1);
    check_nominal_trace(K2, N1, D1);
    @(negedge clk);

    // reset during the data-write issue cycle
    @(negedge clk);
    req_key = K1; req_nonce = N1; req_data = D1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      @(negedge clk);
      if (cs && address == 8'h30) hit = 1;
    end
    check("rst_mid_reached_wr_data", 512'(hit), 512'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_cs_async", 512'(cs), 512'd0);
    check("rst_mid_we_async", 512'(we), 512'd0);
    check("rst_mid_busy", 512'(busy), 512'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", 512'(req_ready), 512'd1);
    check("rst_mid_no_rsp", 512'(rsp_valid), 512'd0);
    run_job(K1, N1, D1, 0, R2, 1'b0);
    check("rst_new_rsp_cycle", 512'(rsp_cyc), 512'd15);
    check("rst_new_rsp_data", rsp_data, R2);
    check_nominal_trace(K1, N1, D1);
    @(negedge clk);

    check("cs_never_back_to_back", 512'(cs_double), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
